register_write_demux_16: RTL and testbench

Write-side counterpart of the 16-to-1 read multiplexer in the register datapath. The block accepts 32-bit write requests over a valid/ready handshake and buffers each one for a cycle. It decodes the 4-bit address into 16 one-hot enables and commits the data into one of 16 32-bit registers. The 16 register outputs feed the read multiplexer's 16 data inputs directly.

---
 rtl/register_write_demux_16.sv | 129 ++++++++++++
 tb/tb_register_write_demux_16.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/register_write_demux_16.sv
// register_write_demux_16
// Write side of the 16 x 32-bit register file. A write request is captured
// into a one-entry hold stage, then committed into the addressed register on
// the next edge unless the control unit asserts freeze. The 16 register
// contents are exported directly as q0..q15 for the read multiplexer.
//
// Optional feature macro: REG0_ZERO_EN
//   defined   : register 0 reads as constant zero; writes to it still
//               handshake, pulse write_done and bump write_count.
//   undefined : register 0 is an ordinary writable register.
module register_write_demux_16 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [3:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        freeze,
  output logic [31:0] q0,
  output logic [31:0] q1,
  output logic [31:0] q2,
  output logic [31:0] q3,
  output logic [31:0] q4,
  output logic [31:0] q5,
  output logic [31:0] q6,
  output logic [31:0] q7,
  output logic [31:0] q8,
  output logic [31:0] q9,
  output logic [31:0] q10,
  output logic [31:0] q11,
  output logic [31:0] q12,
  output logic [31:0] q13,
  output logic [31:0] q14,
  output logic [31:0] q15,
  output logic        pend_valid,
  output logic [3:0]  pend_addr,
  output logic        write_done,
  output logic [7:0]  write_count
);

  localparam int DATA_W = 32;
  localparam int NREGS  = 16;

  logic [DATA_W-1:0] hold_data_p0;
  logic [DATA_W-1:0] regs_p1 [NREGS];
  logic              capture;
  logic              commit;
  logic [NREGS-1:0]  wr_en;

  // One-hot 4-to-16 decode, all zeros when not enabled.
  function automatic logic [NREGS-1:0] decode_4to16(input logic [3:0] addr,
                                                    input logic       en);
    logic [NREGS-1:0] onehot;
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
    return onehot;
  endfunction

  // Handshake and commit qualifiers; ready never depends on wr_valid.
  always_comb begin
    wr_ready = !pend_valid || !freeze;
    capture  = wr_valid && wr_ready;
    commit   = pend_valid && !freeze;
`ifdef REG0_ZERO_EN
    wr_en    = decode_4to16(pend_addr, commit) & ~{{(NREGS-1){1'b0}}, 1'b1};
`else
    wr_en    = decode_4to16(pend_addr, commit);
`endif
  end

  // ---- Stage p0: capture request into the hold register ----
  // Hold stage: loads on capture, empties on a commit with nothing new behind it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid   <= 1'b0;
      pend_addr    <= 4'd0;
      hold_data_p0 <= '0;
    end else begin
      if (capture) begin
        pend_valid   <= 1'b1;
        pend_addr    <= wr_addr;
        hold_data_p0 <= wr_data;
      end else if (commit) begin
        pend_valid   <= 1'b0;
      end
    end
  end

  // ---- Stage p1: commit held data into the addressed register ----
  // Register file: only the decoded register loads; the rest hold their value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs_p1[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wr_en[i]) regs_p1[i] <= hold_data_p0;
      end
    end
  end

  // Commit status: done pulse follows each commit edge; counter wraps at 256.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      write_done  <= 1'b0;
      write_count <= 8'd0;
    end else begin
      write_done <= commit;
      if (commit) write_count <= write_count + 8'd1;
    end
  end

  assign q0  = regs_p1[0];
  assign q1  = regs_p1[1];
  assign q2  = regs_p1[2];
  assign q3  = regs_p1[3];
  assign q4  = regs_p1[4];
  assign q5  = regs_p1[5];
  assign q6  = regs_p1[6];
  assign q7  = regs_p1[7];
  assign q8  = regs_p1[8];
  assign q9  = regs_p1[9];
  assign q10 = regs_p1[10];
  assign q11 = regs_p1[11];
  assign q12 = regs_p1[12];
  assign q13 = regs_p1[13];
  assign q14 = regs_p1[14];
  assign q15 = regs_p1[15];

endmodule

// File: tb/tb_register_write_demux_16.sv
// Directed bench for register_write_demux_16: reset, single and back-to-back
// writes, freeze stall with a held request, mid-operation reset, counter
// wrap and the register-0 option.
module tb_register_write_demux_16;

  logic        clk;
  logic        reset_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        freeze;
  logic [31:0] q [16];
  logic        pend_valid;
  logic [3:0]  pend_addr;
  logic        write_done;
  logic [7:0]  write_count;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] exp_q0;

  register_write_demux_16 dut (
    .clk(clk), .reset_n(reset_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .freeze(freeze),
    .q0(q[0]),   .q1(q[1]),   .q2(q[2]),   .q3(q[3]),
    .q4(q[4]),   .q5(q[5]),   .q6(q[6]),   .q7(q[7]),
    .q8(q[8]),   .q9(q[9]),   .q10(q[10]), .q11(q[11]),
    .q12(q[12]), .q13(q[13]), .q14(q[14]), .q15(q[15]),
    .pend_valid(pend_valid), .pend_addr(pend_addr),
    .write_done(write_done), .write_count(write_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n  = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = 4'd0;
    wr_data  = 32'd0;
    freeze   = 1'b0;

    // Reset state
    tick(); tick();
    for (int i = 0; i < 16; i++) chk($sformatf("rst_q%0d", i), q[i], 32'd0);
    chk("rst_pend_valid", {31'd0, pend_valid}, 32'd0);
    chk("rst_pend_addr", {28'd0, pend_addr}, 32'd0);
    chk("rst_write_done", {31'd0, write_done}, 32'd0);
    chk("rst_write_count", {24'd0, write_count}, 32'd0);
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // Single write: (1, 0xA)
    @(negedge clk);
    wr_valid = 1'b1; wr_addr = 4'd1; wr_data = 32'h0000000A;
    tick();
    wr_valid = 1'b0;
    chk("w1_pend_valid", {31'd0, pend_valid}, 32'd1);
    chk("w1_pend_addr", {28'd0, pend_addr}, 32'd1);
    chk("w1_q1_before_commit", q[1], 32'd0);
    tick();
    chk("w1_q1", q[1], 32'h0000000A);
    chk("w1_done", {31'd0, write_done}, 32'd1);
    chk("w1_count", {24'd0, write_count}, 32'd1);
    chk("w1_pend_clear", {31'd0, pend_valid}, 32'd0);
    for (int i = 0; i < 16; i++)
      if (i != 1) chk($sformatf("w1_other_q%0d", i), q[i], 32'd0);
    tick();
    chk("w1_done_drop", {31'd0, write_done}, 32'd0);

    // Back-to-back: (14,BBB) (14,CCC) (2,B)
    wr_valid = 1'b1; wr_addr = 4'd14; wr_data = 32'h00000BBB;
    tick();
    wr_addr = 4'd14; wr_data = 32'h00000CCC;
    tick();
    chk("b2b_done1", {31'd0, write_done}, 32'd1);
    chk("b2b_q14_first", q[14], 32'h00000BBB);
    wr_addr = 4'd2; wr_data = 32'h0000000B;
    tick();
    wr_valid = 1'b0;
    chk("b2b_done2", {31'd0, write_done}, 32'd1);
    chk("b2b_q14_last", q[14], 32'h00000CCC);
    tick();
    chk("b2b_done3", {31'd0, write_done}, 32'd1);
    chk("b2b_q2", q[2], 32'h0000000B);
    chk("b2b_q14_final", q[14], 32'h00000CCC);
    chk("b2b_count", {24'd0, write_count}, 32'd4);
    tick();
    chk("b2b_done_drop", {31'd0, write_done}, 32'd0);

    // Freeze stall with a second request held by the source
    wr_valid = 1'b1; wr_addr = 4'd5; wr_data = 32'hDEADBEEF;
    tick();
    wr_addr = 4'd6; wr_data = 32'h00000066;
    freeze = 1'b1;
    #1;
    chk("frz_ready_low", {31'd0, wr_ready}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("frz_pend_valid_c%0d", c), {31'd0, pend_valid}, 32'd1);
      chk($sformatf("frz_pend_addr_c%0d", c), {28'd0, pend_addr}, 32'd5);
      chk($sformatf("frz_q5_c%0d", c), q[5], 32'd0);
      chk($sformatf("frz_count_c%0d", c), {24'd0, write_count}, 32'd4);
    end
    chk("frz_done_low", {31'd0, write_done}, 32'd0);
    freeze = 1'b0;
    #1;
    chk("unfrz_ready", {31'd0, wr_ready}, 32'd1);
    tick();
    wr_valid = 1'b0;
    chk("unfrz_q5", q[5], 32'hDEADBEEF);
    chk("unfrz_same_edge_pend", {31'd0, pend_valid}, 32'd1);
    chk("unfrz_same_edge_addr", {28'd0, pend_addr}, 32'd6);
    chk("unfrz_count", {24'd0, write_count}, 32'd5);
    tick();
    chk("unfrz_q6", q[6], 32'h00000066);
    chk("unfrz_count2", {24'd0, write_count}, 32'd6);

    // Freeze with empty hold stage still accepts one request
    freeze = 1'b1;
    #1;
    chk("frz_empty_ready", {31'd0, wr_ready}, 32'd1);
    wr_valid = 1'b1; wr_addr = 4'd8; wr_data = 32'h00000088;
    tick();
    wr_valid = 1'b0;
    chk("frz_empty_capt", {31'd0, pend_valid}, 32'd1);
    chk("frz_empty_ready_low", {31'd0, wr_ready}, 32'd0);
    tick();
    chk("frz_empty_q8_held", q[8], 32'd0);
    freeze = 1'b0;
    tick();
    chk("frz_empty_q8", q[8], 32'h00000088);

    // Reset mid-operation discards the pending write
    wr_valid = 1'b1; wr_addr = 4'd7; wr_data = 32'h12345678;
    tick();
    wr_valid = 1'b0;
    freeze = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("mrst_q7", q[7], 32'd0);
    chk("mrst_q5", q[5], 32'd0);
    chk("mrst_pend_valid", {31'd0, pend_valid}, 32'd0);
    chk("mrst_count", {24'd0, write_count}, 32'd0);
    chk("mrst_ready", {31'd0, wr_ready}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    freeze = 1'b0;
    tick(); tick();
    chk("mrst_q7_after", q[7], 32'd0);
    chk("mrst_count_after", {24'd0, write_count}, 32'd0);
    chk("mrst_done_after", {31'd0, write_done}, 32'd0);

    // Wrap-around: 256 commits to address 3
    wr_valid = 1'b1; wr_addr = 4'd3;
    for (int i = 0; i < 256; i++) begin
      wr_data = 32'(i + 1);
      tick();
    end
    wr_valid = 1'b0;
    chk("wrap_count_255", {24'd0, write_count}, 32'd255);
    tick();
    chk("wrap_count_0", {24'd0, write_count}, 32'd0);
    chk("wrap_q3", q[3], 32'h00000100);

    // Register 0 behaviour
`ifdef REG0_ZERO_EN
    exp_q0 = 32'h00000000;
`else
    exp_q0 = 32'hFFFFFFFF;
`endif
    wr_valid = 1'b1; wr_addr = 4'd0; wr_data = 32'hFFFFFFFF;
    tick();
    wr_valid = 1'b0;
    tick();
    chk("r0_q0", q[0], exp_q0);
    chk("r0_count", {24'd0, write_count}, 32'd1);
    chk("r0_done", {31'd0, write_done}, 32'd1);
    chk("r0_q3_untouched", q[3], 32'h00000100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
